// File: rtl/gat_pkg.sv
// Shared types and sizing helpers for the GAT layer scheduler.
// The CLEAR state exists only when GAT_FEAT_CLEAR_EN is defined.
package gat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
`ifdef GAT_FEAT_CLEAR_EN
        ST_CLEAR     = 3'd2,
`endif
        ST_START     = 3'd3,
        ST_RUN       = 3'd4,
        ST_DONE      = 3'd5
    } gat_state_e;

    localparam int GAT_NUM_LOAD_FLAGS = 3;

    function automatic int gat_feature_depth(input int num_subgraphs, input int num_feature_out);
        return num_subgraphs * num_feature_out;
    endfunction

    // A depth of 1 still needs a one-bit address bus.
    function automatic int gat_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gat_addr_counter.sv
// Saturating address counter with synchronous clear and a terminal-count flag;
// shared by the zero-fill sweep and the result-write phase.
module gat_addr_counter #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == LAST);
    assign cnt_o = cnt_q;

    // NOTE: every path assigns cnt_d from a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gat_layer_scheduler.sv
// Sequences one GAT layer: wait for host loads, optional zero-fill, kick the core,
// then stream core results into the new-feature BRAM. Zero-fill: GAT_FEAT_CLEAR_EN.
module gat_layer_scheduler
    import gat_pkg::*;
#(
    parameter  int DATA_WIDTH         = 8,
    parameter  int NUM_SUBGRAPHS      = 2708,
    parameter  int NUM_FEATURE_OUT    = 16,
    localparam int NEW_FEATURE_DEPTH  = gat_feature_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
    localparam int NEW_FEATURE_ADDR_W = gat_addr_width(NEW_FEATURE_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gat_layer,
    input  logic                          h_data_bram_load_done,
    input  logic                          h_node_info_bram_load_done,
    input  logic                          wgt_bram_load_done,
    output logic                          gat_ready,
    output logic                          core_start,
    input  logic                          feat_wr_valid,
    input  logic [DATA_WIDTH-1:0]         feat_wr_data,
    output logic                          feat_wr_ready,
    output logic                          feat_bram_ena,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addra,
    output logic [DATA_WIDTH-1:0]         feat_bram_din,
    output logic                          busy
);

    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR =
        NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

    gat_state_e state_q;
    gat_state_e state_d;

    logic                            gat_layer_q;
    logic                            armed_q;
    logic                            start_q;
    logic [GAT_NUM_LOAD_FLAGS-1:0]   load_flags;
    logic [GAT_NUM_LOAD_FLAGS-1:0]   load_flags_q;
    logic                            gat_ready_q;
    logic                            core_start_q;
    logic                            busy_q;

    logic [NEW_FEATURE_ADDR_W-1:0]   addr_cnt;
    logic                            addr_tc;
    logic                            cnt_clr;
    logic                            cnt_en;
    logic                            xfer;

    assign load_flags = {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done};

    assign feat_wr_ready = (state_q == ST_RUN);
    assign xfer          = feat_wr_ready & feat_wr_valid;
    assign cnt_clr       = (state_q inside {ST_IDLE, ST_WAIT_LOAD, ST_START, ST_DONE});

`ifdef GAT_FEAT_CLEAR_EN
    logic clr_phase;

    assign clr_phase     = (state_q == ST_CLEAR);
    assign cnt_en        = clr_phase | xfer;
    assign feat_bram_ena = clr_phase | xfer;
`else
    assign cnt_en        = xfer;
    assign feat_bram_ena = xfer;
`endif

    // Idle write port shows zero address/data rather than the stale counter.
    assign feat_bram_addra = feat_bram_ena ? addr_cnt : '0;
    assign feat_bram_din   = xfer ? feat_wr_data : '0;

    assign gat_ready  = gat_ready_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;

    gat_addr_counter #(
        .WIDTH (NEW_FEATURE_ADDR_W),
        .LAST  (LAST_ADDR)
    ) u_addr_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (addr_cnt),
        .tc_o  (addr_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_q) state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                if (&load_flags) begin
`ifdef GAT_FEAT_CLEAR_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_START;
`endif
                end else if (|(load_flags_q & ~load_flags)) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef GAT_FEAT_CLEAR_EN
            ST_CLEAR: begin
                if (addr_tc) state_d = ST_START;
            end
`endif
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (xfer && addr_tc) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_q) state_d = ST_WAIT_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // armed_q masks the first cycle after reset so a level already high is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gat_layer_q  <= 1'b0;
            armed_q      <= 1'b0;
            start_q      <= 1'b0;
            load_flags_q <= '0;
            gat_ready_q  <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            armed_q      <= 1'b1;
            gat_layer_q  <= gat_layer;
            start_q      <= gat_layer & ~gat_layer_q & armed_q;
            load_flags_q <= load_flags;
            state_q      <= state_d;
            gat_ready_q  <= (state_d == ST_DONE);
            core_start_q <= (state_d == ST_START);
            busy_q       <= !(state_d inside {ST_IDLE, ST_DONE});
        end
    end

endmodule

// File: doc/gat_layer_scheduler.md
GAT_LAYER_SCHEDULER -- requirements
Module: gat_layer_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the new-feature element width.
REQ-002 SHALL have parameter NUM_SUBGRAPHS, default 2708, the number of subgraphs per layer.
REQ-003 SHALL have parameter NUM_FEATURE_OUT, default 16, the number of output features per subgraph.
REQ-004 SHALL derive NEW_FEATURE_DEPTH = NUM_SUBGRAPHS*NUM_FEATURE_OUT and NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port gat_layer, input, 1 bit: level start request from the register bank.
REQ-008 SHALL have ports h_data_bram_load_done, h_node_info_bram_load_done and wgt_bram_load_done, input, 1 bit each: host load-complete flags.
REQ-009 SHALL have port gat_ready, output, 1 bit: layer result available.
REQ-010 SHALL have port core_start, output, 1 bit: one-cycle start pulse to the compute core.
REQ-011 SHALL have ports feat_wr_valid (input, 1), feat_wr_data (input, DATA_WIDTH) and feat_wr_ready (output, 1): core result stream.
REQ-012 SHALL have ports feat_bram_ena (output, 1), feat_bram_addra (output, NEW_FEATURE_ADDR_W) and feat_bram_din (output, DATA_WIDTH): new-feature BRAM port A, write-only.
REQ-013 SHALL have port busy, output, 1 bit: the FSM is not in IDLE or DONE.

Function
REQ-014 SHALL implement the states IDLE, WAIT_LOAD, CLEAR, START, RUN and DONE.
REQ-015 SHALL detect a start as a rising edge of gat_layer, registered one cycle; a level held high SHALL NOT retrigger.
REQ-016 SHALL go IDLE->WAIT_LOAD on a start, and DONE->WAIT_LOAD on a start.
REQ-017 SHALL go WAIT_LOAD->CLEAR (or ->START when clear is compiled out) in the cycle after all three load_done flags are sampled high together.
REQ-018 SHALL, in CLEAR, drive feat_bram_ena=1 and feat_bram_din=0 with feat_bram_addra counting 0..NEW_FEATURE_DEPTH-1 at one per cycle, then go to START.
REQ-019 SHALL spend exactly 1 cycle in START, assert core_start for that cycle, reset the address counter to 0, then go to RUN.
REQ-020 SHALL, in RUN, assert feat_wr_ready combinationally; a transfer occurs when feat_wr_valid and feat_wr_ready are both 1.
REQ-021 SHALL, in a transfer cycle, drive feat_bram_ena=1, feat_bram_addra=counter and feat_bram_din=feat_wr_data, and increment the counter.
REQ-022 SHALL drive feat_bram_ena=0 in RUN cycles with no transfer, and hold the counter.
REQ-023 SHALL go RUN->DONE in the cycle after the transfer at address NEW_FEATURE_DEPTH-1; the counter SHALL NOT wrap, and feat_wr_ready SHALL be 0 outside RUN.
REQ-024 SHALL hold gat_ready=1 only in DONE; gat_ready SHALL fall in the cycle WAIT_LOAD is entered.
REQ-025 SHALL ignore a start seen during WAIT_LOAD, CLEAR, START or RUN, with no restart and no queueing.
REQ-026 SHALL return WAIT_LOAD->IDLE, with no outputs asserted, if any load_done flag falls while in WAIT_LOAD.
REQ-027 SHALL make the counter exactly NEW_FEATURE_ADDR_W bits; the comparisons SHALL use NEW_FEATURE_DEPTH-1 so that no overflow bit is needed.

Reset
REQ-028 SHALL, while rst_n=0 asynchronously, set the state to IDLE, the counter to 0, the start-edge register to 0, and gat_ready, core_start, busy, feat_wr_ready, feat_bram_ena, feat_bram_addra and feat_bram_din to 0.
REQ-029 SHALL abandon any operation, including mid-RUN and mid-CLEAR, on reset; a partial BRAM content is acceptable, and there SHALL be no further writes until a new start.
REQ-030 SHALL require, after reset release, a new rising edge of gat_layer; a level already high at release SHALL NOT start a run.

Configuration
REQ-031 SHALL include the CLEAR state and the zero-fill when the macro GAT_FEAT_CLEAR_EN is defined.
REQ-032 SHALL, when GAT_FEAT_CLEAR_EN is undefined, remove the CLEAR state, go WAIT_LOAD->START directly, and have no zero-fill logic.

Structure
REQ-033 SHALL place the state-encoding typedef, the state constants and the depth/width derivation function in the shared gat_pkg package.
REQ-034 SHALL use one sub-module, gat_addr_counter: a NEW_FEATURE_ADDR_W-bit counter with clear, enable and a terminal-count flag, shared by CLEAR and RUN.

Verification
REQ-035 SHALL cover: all three load_done flags high, gat_layer 0->1 -> core_start is pulsed exactly once, after NEW_FEATURE_DEPTH clear cycles (or 2 cycles with clear compiled out).
REQ-036 SHALL cover: in RUN, 32 valid beats with data = addr mod 256 and random valid gaps (NUM_SUBGRAPHS=2, NUM_FEATURE_OUT=16) -> 32 writes at addresses 0..31, no duplicates, then gat_ready=1 on the next cycle.
REQ-037 SHALL cover: wgt_bram_load_done=0 at start -> the FSM stays in WAIT_LOAD; raising it -> the FSM proceeds one cycle later.
REQ-038 SHALL cover: gat_layer toggled during RUN -> no new core_start, and the address sequence is unchanged.
REQ-039 SHALL cover: rst_n asserted at the 10th RUN beat -> all outputs are 0 immediately; after release with gat_layer held high -> the FSM stays in IDLE.
REQ-040 SHALL cover: a start in DONE -> gat_ready falls next cycle, and a second full run rewrites addresses 0..31.
